// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between NUM_REQ writeback
// sources. One requester is granted per cycle; the winning write is registered
// and driven onto the rf_* outputs the following cycle. Writes to x0 complete
// their handshake but never raise rf_reg_write. Cycles with two or more
// requesters contending (and no hold) are counted in a saturating counter.
//
// Configuration macro:
//   REGFILE_WRITE_ARB_RR_EN  defined   -> round-robin arbitration
//                            undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk             clock, all state on rising edge
//   reset_n         synchronous active-low reset
//   req_valid       per-requester write pending
//   req_rd          packed destination indices, slice i = [i*ADDR_W +: ADDR_W]
//   req_data        packed write data, slice i = [i*DATA_W +: DATA_W]
//   req_ready       one-hot or zero, requester accepted this cycle
//   hold            pipeline freeze, blocks all grants
//   rf_reg_write    register-file write enable
//   rf_rd           register-file destination index
//   rf_write_data   register-file write data
//   grant_id        index of requester whose write is on rf_*
//   conflict_count  saturating count of contended, non-held cycles
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_rd,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         hold,
    output logic                         rf_reg_write,
    output logic [ADDR_W-1:0]            rf_rd,
    output logic [DATA_W-1:0]            rf_write_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic [15:0]                  conflict_count
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    // Arbitration result
    logic               found;
    logic [IdW-1:0]     win_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               transfer;
    logic [ADDR_W-1:0]  win_rd;
    logic [DATA_W-1:0]  win_data;

    // Output stage and counter
    logic               rf_reg_write_q, rf_reg_write_d;
    logic [ADDR_W-1:0]  rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]  rf_write_data_q, rf_write_data_d;
    logic [IdW-1:0]     grant_id_q, grant_id_d;
    logic [15:0]        conflict_count_q, conflict_count_d;
    logic               multi_valid;

`ifdef REGFILE_WRITE_ARB_RR_EN
    logic [IdW-1:0] ptr_q, ptr_d;

    // Search upward from ptr+1 with wrap; first valid requester wins.
    always_comb begin
        logic [IdW-1:0] cand;
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdW'((32'(ptr_q) + 32'd1 + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = win_idx;
        end
    end
`else
    // Fixed priority: scan downward so the lowest valid index is left last.
    always_comb begin
        logic [IdW-1:0] cand;
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IdW'(k);
            if (req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end
`endif

    // Grants are killed by hold and combinationally by reset.
    assign transfer = found & reset_n & ~hold;

    always_comb begin
        gnt      = '0;
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IdW'(i)) begin
                gnt[i]   = 1'b1;
                win_rd   = req_rd[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = transfer ? gnt : '0;

    // Two or more bits set <=> clearing the lowest set bit leaves something.
    assign multi_valid = (req_valid & (req_valid - NUM_REQ'(1))) != '0;

    always_comb begin
        rf_reg_write_d   = 1'b0;
        rf_rd_d          = rf_rd_q;
        rf_write_data_d  = rf_write_data_q;
        grant_id_d       = grant_id_q;
        conflict_count_d = conflict_count_q;
        if (transfer) begin
            rf_reg_write_d  = (win_rd != '0);
            rf_rd_d         = win_rd;
            rf_write_data_d = win_data;
            grant_id_d      = win_idx;
        end
        if (multi_valid && !hold && (conflict_count_q != 16'hFFFF)) begin
            conflict_count_d = conflict_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_reg_write_q   <= 1'b0;
            rf_rd_q          <= '0;
            rf_write_data_q  <= '0;
            grant_id_q       <= '0;
            conflict_count_q <= '0;
        end else begin
            rf_reg_write_q   <= rf_reg_write_d;
            rf_rd_q          <= rf_rd_d;
            rf_write_data_q  <= rf_write_data_d;
            grant_id_q       <= grant_id_d;
            conflict_count_q <= conflict_count_d;
        end
    end

`ifdef REGFILE_WRITE_ARB_RR_EN
    // Reset to NUM_REQ-1 so requester 0 has top priority after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= IdW'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign rf_reg_write   = rf_reg_write_q;
    assign rf_rd          = rf_rd_q;
    assign rf_write_data  = rf_write_data_q;
    assign grant_id       = grant_id_q;
    assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_rd;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              hold;
    logic              rf_reg_write;
    logic [AW-1:0]     rf_rd;
    logic [DW-1:0]     rf_write_data;
    logic [0:0]        grant_id;
    logic [15:0]       conflict_count;

    regfile_write_arbiter #(
        .NUM_REQ(NR),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .hold          (hold),
        .rf_reg_write  (rf_reg_write),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .grant_id      (grant_id),
        .conflict_count(conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        gid;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Drive one cycle of stimulus, check req_ready, queue the expected rf_* state.
    task automatic step(input string name, input logic rstn, input logic hld,
                        input logic [1:0] vld,
                        input logic [4:0] rd0, input logic [31:0] d0,
                        input logic [4:0] rd1, input logic [31:0] d1,
                        input logic [1:0] exp_rdy,
                        input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_data,
                        input logic e_gid, input logic [15:0] e_cnt);
        exp_t e;
        @(negedge clk);
        reset_n   = rstn;
        hold      = hld;
        req_valid = vld;
        req_rd    = {rd1, rd0};
        req_data  = {d1, d0};
        #1;
        n_vec++;
        if (req_ready !== exp_rdy) begin
            n_miss++;
            $display("FAIL %s ready: got %b expected %b", name, req_ready, exp_rdy);
        end
        e.we = e_we; e.rd = e_rd; e.data = e_data; e.gid = e_gid; e.cnt = e_cnt;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare the output stage to the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (rf_reg_write !== e.we || rf_rd !== e.rd || rf_write_data !== e.data ||
                    grant_id !== e.gid || conflict_count !== e.cnt) begin
                    n_miss++;
                    $display("FAIL %s out: got we=%b rd=%0d data=%h gid=%0d cnt=%0d expected we=%b rd=%0d data=%h gid=%0d cnt=%0d",
                             e.name, rf_reg_write, rf_rd, rf_write_data, grant_id,
                             conflict_count, e.we, e.rd, e.data, e.gid, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [1:0]  c_rdy;
        logic [4:0]  c_rd;
        logic [31:0] c_data;
        logic        c_gid;
        int          wait_cyc;

        reset_n   = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;

        // Reset with everything requesting.
        for (int i = 0; i < 3; i++)
            step("reset", 1'b0, 1'b0, 2'b11, 5'd5, 32'h1, 5'd6, 32'h2,
                 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 16'd0);

        step("single", 1'b1, 1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,
             2'b01, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 16'd0);
        step("x0_write", 1'b1, 1'b0, 2'b10, 5'd0, 32'h0, 5'd0, 32'h1234,
             2'b10, 1'b0, 5'd0, 32'h1234, 1'b1, 16'd0);
        step("idle", 1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
             2'b00, 1'b0, 5'd0, 32'h1234, 1'b1, 16'd0);

        // Contention: rr alternates 0,1,0,1; fixed always picks 0.
        for (int i = 0; i < 4; i++) begin
`ifdef REGFILE_WRITE_ARB_RR_EN
            c_gid = (i % 2 == 1);
`else
            c_gid = 1'b0;
`endif
            c_rdy  = c_gid ? 2'b10 : 2'b01;
            c_rd   = c_gid ? 5'd4 : 5'd3;
            c_data = c_gid ? 32'hB1 : 32'hA0;
            step("contend", 1'b1, 1'b0, 2'b11, 5'd3, 32'hA0, 5'd4, 32'hB1,
                 c_rdy, 1'b1, c_rd, c_data, c_gid, 16'(i + 1));
        end

        // Hold: no grants, previous rf_rd/data/gid retained.
        for (int i = 0; i < 3; i++)
            step("hold", 1'b1, 1'b1, 2'b01, 5'd9, 32'hC0DE, 5'd0, 32'h0,
                 2'b00, 1'b0, c_rd, c_data, c_gid, 16'd4);
        step("hold_release", 1'b1, 1'b0, 2'b01, 5'd9, 32'hC0DE, 5'd0, 32'h0,
             2'b01, 1'b1, 5'd9, 32'hC0DE, 1'b0, 16'd4);
        // Contention under hold is not counted.
        step("hold_conflict", 1'b1, 1'b1, 2'b11, 5'd9, 32'hC0DE, 5'd8, 32'h88,
             2'b00, 1'b0, 5'd9, 32'hC0DE, 1'b0, 16'd4);

        // Reset mid-operation drops the pending write and clears the counter.
        step("pre_reset", 1'b1, 1'b0, 2'b01, 5'd7, 32'h77, 5'd0, 32'h0,
             2'b01, 1'b1, 5'd7, 32'h77, 1'b0, 16'd4);
        step("mid_reset", 1'b0, 1'b0, 2'b11, 5'd7, 32'h77, 5'd2, 32'h22,
             2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 16'd0);
        step("post_reset", 1'b1, 1'b0, 2'b10, 5'd7, 32'h77, 5'd2, 32'h22,
             2'b10, 1'b1, 5'd2, 32'h22, 1'b1, 16'd0);
        step("idle2", 1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
             2'b00, 1'b0, 5'd2, 32'h22, 1'b1, 16'd0);
        step("contend2", 1'b1, 1'b0, 2'b11, 5'd3, 32'hA0, 5'd4, 32'hB1,
             2'b01, 1'b1, 5'd3, 32'hA0, 1'b0, 16'd1);

        // Drain the scoreboard with a bounded wait.
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #5;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
